// File: rtl/mac_array_ctrl.sv
// ---------------------------------------------------------------------------
// mac_array_ctrl
//
// Sequencer for a row x col MAC array. One job = load col kernel words,
// wait row+col cycles for the weights to settle through the array, stream
// N activation words, then wait for N results to fall out of the last
// column before signalling completion.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      job request (honoured only when idle and num_x != 0)
//   num_x      number of activation vectors N for the job
//   w_base     address of the first kernel word
//   x_base     address of the first activation word
//   mem_rd_en  memory read strobe (data returns one cycle later)
//   mem_addr   memory read address (wraps modulo 2^aw)
//   inst_w     array instruction, bit1 = execute, bit0 = kernel load
//   valid      per-column result valid from the array
//   psum_wr    psum store write strobe
//   busy       job in progress
//   done       one-cycle completion pulse
//   err        drain timeout; valid with done, held until next accepted start
// ---------------------------------------------------------------------------
module mac_array_ctrl #(
    parameter int bw  = 4,
    parameter int row = 8,
    parameter int col = 8,
    parameter int aw  = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      num_x,
    input  logic [aw-1:0]   w_base,
    input  logic [aw-1:0]   x_base,
    output logic            mem_rd_en,
    output logic [aw-1:0]   mem_addr,
    output logic [1:0]      inst_w,
    input  logic [col-1:0]  valid,
    output logic            psum_wr,
    output logic            busy,
    output logic            done,
    output logic            err
);

    // Parameter sanity; the data width itself lives in the array, not here.
    if (bw < 1 || row < 1 || col < 2 || aw < 1) begin : g_bad_params
        $error("mac_array_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, KLOAD, GAP, EXEC, DRAIN, FIN} state_t;

    localparam logic [15:0]   KLOAD_LAST = 16'(col - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(row + col - 1);
    localparam logic [15:0]   DRAIN_LAST = 16'(row + col + 4 - 1);
    localparam logic [aw-1:0] ADDR_ONE   = aw'(1);

    state_t        state;
    logic [15:0]   cnt;        // cycles spent in the current phase
    logic [7:0]    n_r;        // latched N
    logic [aw-1:0] x_base_r;   // latched activation base
    logic [7:0]    vcnt;       // results seen on the last column, saturates at N
    logic [7:0]    vcnt_next;
    logic          counting;
    logic [15:0]   exec_last;

    // Only the last column's valid marks a finished output vector.
    logic unused_valid;
    assign unused_valid = ^valid[col-2:0];

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        counting  = (state == EXEC) || (state == DRAIN);
        psum_wr   = counting && valid[col-1] && (vcnt < n_r);
        vcnt_next = vcnt + {7'd0, psum_wr};
        exec_last = {8'd0, n_r} - 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            n_r       <= '0;
            x_base_r  <= '0;
            vcnt      <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            inst_w    <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Instruction trails the read by one cycle to line up with data.
            inst_w <= {mem_rd_en && (state == EXEC), mem_rd_en && (state == KLOAD)};
            done   <= 1'b0;
            if (counting) vcnt <= vcnt_next;

            case (state)
                IDLE: begin
                    if (start && (num_x != 8'd0)) begin
                        n_r       <= num_x;
                        x_base_r  <= x_base;
                        mem_addr  <= w_base;
                        mem_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        cnt       <= '0;
                        vcnt      <= '0;
                        state     <= KLOAD;
                    end
                end
                KLOAD: begin
                    if (cnt == KLOAD_LAST) begin
                        cnt       <= '0;
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                        state     <= GAP;
                    end else begin
                        cnt      <= cnt + 16'd1;
                        mem_addr <= mem_addr + ADDR_ONE;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= x_base_r;
                        state     <= EXEC;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                EXEC: begin
                    if (cnt == exec_last) begin
                        cnt       <= '0;
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                        // All results already in: skip DRAIN entirely.
                        if (vcnt_next == n_r) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt      <= cnt + 16'd1;
                        mem_addr <= mem_addr + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    if (vcnt_next == n_r) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (cnt == DRAIN_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_array_ctrl
//
// Directed bench for mac_array_ctrl (row = col = 8, aw = 11). Cycle 0 of a
// job is the cycle in which start is high; outputs are sampled 1 ns after
// the falling edge. The valid[col-1] pulse schedule is given per job.
// ---------------------------------------------------------------------------
module tb_mac_array_ctrl;

    localparam int BW  = 4;
    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int X0  = 1 + COL + ROW + COL;   // first EXEC cycle (25)

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    num_x;
    logic [AW-1:0] w_base;
    logic [AW-1:0] x_base;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [1:0]    inst_w;
    logic [COL-1:0] valid;
    logic          psum_wr;
    logic          busy;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;
    bit vsched [0:127];

    mac_array_ctrl #(.bw(BW), .row(ROW), .col(COL), .aw(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_x     (num_x),
        .w_base    (w_base),
        .x_base    (x_base),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .inst_w    (inst_w),
        .valid     (valid),
        .psum_wr   (psum_wr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_sched();
        foreach (vsched[i]) vsched[i] = 1'b0;
    endtask

    // Runs one job from cycle 0 to exp_done+4, checking every cycle against
    // the hand-derived timeline. restart_c > 0 pulses start at that cycle.
    task automatic run_job(input int n, input int wb, input int xb,
                           input int exp_done, input bit exp_err,
                           input int exp_psum, input int restart_c);
        int            psum_seen;
        bit            er;
        logic [AW-1:0] ea;
        logic [1:0]    ei;
        psum_seen = 0;
        @(negedge clk);
        reset  = 1'b0;
        start  = 1'b1;
        num_x  = 8'(n);
        w_base = AW'(wb);
        x_base = AW'(xb);
        valid  = '0;
        #1;
        check("c0 busy", busy, 0);
        check("c0 done", done, 0);
        check("c0 rd_en", mem_rd_en, 0);
        check("c0 inst_w", inst_w, 0);
        for (int c = 1; c <= exp_done + 4; c++) begin
            @(negedge clk);
            start = (c == restart_c);
            valid = '0;
            valid[COL-1] = vsched[c];
            #1;
            er = (c >= 1 && c <= COL) || (c >= X0 && c < X0 + n);
            ea = !er ? '0 : (c <= COL) ? AW'(wb + c - 1) : AW'(xb + c - X0);
            ei = (c >= 2 && c <= COL + 1)   ? 2'b01 :
                 (c >= X0 + 1 && c <= X0 + n) ? 2'b10 : 2'b00;
            check($sformatf("rd_en c%0d", c), mem_rd_en, er);
            check($sformatf("addr c%0d", c), mem_addr, ea);
            check($sformatf("inst_w c%0d", c), inst_w, ei);
            check($sformatf("busy c%0d", c), busy, (c < exp_done));
            check($sformatf("done c%0d", c), done, (c == exp_done));
            check($sformatf("err c%0d", c), err, (c >= exp_done) ? exp_err : 1'b0);
            if (psum_wr) psum_seen++;
        end
        valid = '0;
        start = 1'b0;
        check("psum_count", psum_seen, exp_psum);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        num_x  = '0;
        w_base = '0;
        x_base = '0;
        valid  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst rd_en", mem_rd_en, 0);
        check("rst addr", mem_addr, 0);
        check("rst inst_w", inst_w, 0);
        check("rst psum_wr", psum_wr, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);

        // Basic job; stray pulse in GAP ignored, start during EXEC ignored.
        clear_sched();
        vsched[20] = 1; vsched[27] = 1; vsched[30] = 1; vsched[31] = 1; vsched[33] = 1;
        run_job(4, 'h010, 'h100, 34, 1'b0, 4, 26);

        // num_x == 0 is not a job.
        @(negedge clk);
        start = 1'b1;
        num_x = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("nx0 busy %0d", i), busy, 0);
            check($sformatf("nx0 rd_en %0d", i), mem_rd_en, 0);
        end

        // Only 3 of 4 results: drain timeout after 20 cycles.
        clear_sched();
        vsched[26] = 1; vsched[28] = 1; vsched[30] = 1;
        run_job(4, 'h010, 'h100, 49, 1'b1, 3, -1);

        // Address wrap in both phases; results finish with EXEC (no DRAIN).
        clear_sched();
        vsched[25] = 1; vsched[26] = 1; vsched[27] = 1; vsched[28] = 1; vsched[29] = 1;
        run_job(4, 'h7FC, 'h7FE, 29, 1'b0, 4, -1);

        // Reset in GAP aborts the job without done.
        @(negedge clk);
        start  = 1'b1;
        num_x  = 8'd4;
        w_base = 11'h010;
        x_base = 11'h100;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("abort busy c%0d", c), busy, 1);
            check($sformatf("abort done c%0d", c), done, 0);
            if (c == 12) reset = 1'b1;
        end

        // Start on the first cycle after reset release, full job runs.
        clear_sched();
        vsched[26] = 1; vsched[27] = 1;
        run_job(2, 'h020, 'h040, 28, 1'b0, 2, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
